// File: rtl/block_lock_ctrl.sv
// rtl/block_lock_ctrl.sv - 64b/66b sync-header block-lock FSM with slip request and gated forwarding
module block_lock_ctrl #(
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  s_axis_ttype,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [1:0]  m_axis_ttype,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        slip,
    output logic        block_lock,
    output logic [15:0] slip_count
);
    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int IW = $clog2(SH_INVALID_MAX + 1);
    localparam int WW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SH_CNT_MAX);
    localparam logic [IW-1:0] INV_LAST = IW'(SH_INVALID_MAX);
    localparam logic [WW-1:0] WAIT_LD  = WW'(SLIP_WAIT);

    typedef enum logic [1:0] {ST_TEST, ST_SLIP, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] sh_cnt_q, sh_cnt_d;
    logic [IW-1:0] sh_inv_q, sh_inv_d;
    logic [WW-1:0] wait_q, wait_d;
    logic        lock_q, lock_d;
    logic        slip_q, slip_d;
    logic [15:0] slip_cnt_q, slip_cnt_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic [1:0]  m_ttype_q, m_ttype_d;
    logic [63:0] m_tdata_q, m_tdata_d;

    logic          accept;
    logic          sh_ok;
    logic [CW-1:0] sh_cnt_inc;
    logic [IW-1:0] sh_inv_inc;

    assign s_axis_tready = m_axis_tready;
    assign accept        = s_axis_tvalid & m_axis_tready;
    assign sh_ok         = s_axis_ttype[1] ^ s_axis_ttype[0];
    assign sh_cnt_inc    = sh_cnt_q + CW'(1);
    assign sh_inv_inc    = sh_inv_q + IW'(!sh_ok);

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        sh_inv_d   = sh_inv_q;
        wait_d     = wait_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        slip_cnt_d = slip_cnt_q;
        m_tvalid_d = m_tvalid_q;
        m_ttype_d  = m_ttype_q;
        m_tdata_d  = m_tdata_q;

        // Forwarding uses the lock value held before this cycle's update.
        if (m_axis_tready) begin
            m_tvalid_d = s_axis_tvalid & lock_q;
            m_ttype_d  = s_axis_ttype;
            m_tdata_d  = s_axis_tdata;
        end

        case (state_q)
            ST_TEST: begin
                if (accept) begin
                    sh_cnt_d = sh_cnt_inc;
                    sh_inv_d = sh_inv_inc;
                    if ((!sh_ok && !lock_q) || (sh_inv_inc == INV_LAST)) begin
                        lock_d   = 1'b0;
                        state_d  = ST_SLIP;
                        slip_d   = 1'b1;
                        sh_cnt_d = '0;
                        sh_inv_d = '0;
                    end else if (sh_cnt_inc == CNT_LAST) begin
                        if (sh_inv_inc == '0) lock_d = 1'b1;
                        sh_cnt_d = '0;
                        sh_inv_d = '0;
                    end
                end
            end
            ST_SLIP: begin
                if (slip_cnt_q != 16'hFFFF) slip_cnt_d = slip_cnt_q + 16'd1;
                wait_d  = WAIT_LD;
                state_d = (SLIP_WAIT == 0) ? ST_TEST : ST_WAIT;
            end
            ST_WAIT: begin
                if (accept) begin
                    wait_d = wait_q - WW'(1);
                    if (wait_q == WW'(1)) state_d = ST_TEST;
                end
            end
            default: state_d = ST_TEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_TEST;
            sh_cnt_q   <= '0;
            sh_inv_q   <= '0;
            wait_q     <= '0;
            lock_q     <= 1'b0;
            slip_q     <= 1'b0;
            slip_cnt_q <= 16'd0;
            m_tvalid_q <= 1'b0;
            m_ttype_q  <= 2'b00;
            m_tdata_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            sh_inv_q   <= sh_inv_d;
            wait_q     <= wait_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
            slip_cnt_q <= slip_cnt_d;
            m_tvalid_q <= m_tvalid_d;
            m_ttype_q  <= m_ttype_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_ttype  = m_ttype_q;
    assign m_axis_tdata  = m_tdata_q;
    assign slip          = slip_q;
    assign block_lock    = lock_q;
    assign slip_count    = slip_cnt_q;
endmodule

// File: doc/block_lock_ctrl.md
# block_lock_ctrl

Block-lock controller for the 64b/66b receive path, placed between the RX gearbox and the descrambler. It watches the 2-bit sync header of every accepted block and runs the sync-header lock state machine. On loss of alignment it pulses `slip` to the gearbox, and it forwards blocks to the descrambler only while lock is held. It also reports lock status and a slip counter to management.

## Interface
Parameters:
- `SH_CNT_MAX`, default 64: blocks per test window.
- `SH_INVALID_MAX`, default 16: invalid headers per window that drop lock.
- `SLIP_WAIT`, default 2: accepted blocks discarded after a slip, while the gearbox realigns.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `s_axis_ttype`, in, 2: sync header from the gearbox. 2'b01 and 2'b10 are valid; 2'b00 and 2'b11 are illegal.
- `s_axis_tdata`, in, 64: block payload, still scrambled.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tready`, out, 1: input ready, equal to `m_axis_tready` (combinational).
- `m_axis_ttype`, out, 2: registered sync header toward the descrambler.
- `m_axis_tdata`, out, 64: registered payload toward the descrambler.
- `m_axis_tvalid`, out, 1: registered output valid.
- `m_axis_tready`, in, 1: downstream ready.
- `slip`, out, 1: one-cycle pulse asking the gearbox to shift alignment by one bit.
- `block_lock`, out, 1: lock status.
- `slip_count`, out, 16: saturating count of slips since reset.

## Operation
- **Accepted block:** a cycle with `s_axis_tvalid && s_axis_tready`. All counters and state advance only on accepted blocks.
- **Header check:** `sh_ok = s_axis_ttype[1] ^ s_axis_ttype[0]`.
- **Counter widths:**
  - `sh_cnt` is `$clog2(SH_CNT_MAX+1)` bits.
  - `sh_invalid_cnt` is `$clog2(SH_INVALID_MAX+1)` bits.
  - `wait_cnt` is `$clog2(SLIP_WAIT+1)` bits.
  - No counter wraps; each is cleared explicitly.
- **FSM states:** TEST, SLIP, WAIT.
- **TEST, on each accepted block:**
  - The counters update first: `sh_cnt` += 1, and `sh_invalid_cnt` += 1 if `!sh_ok`. The rules below use these updated values.
  - If `!sh_ok` and `block_lock`=0: go to SLIP, clear both counters.
  - Else, if `sh_invalid_cnt` reaches `SH_INVALID_MAX`: set `block_lock`=0, go to SLIP, clear counters.
  - Else, if `sh_cnt` reaches `SH_CNT_MAX`:
    - If `sh_invalid_cnt`=0, set `block_lock`=1.
    - Clear both counters and stay in TEST.
  - Otherwise stay in TEST.
- **SLIP:**
  - Lasts exactly one cycle, whether or not a block is accepted.
  - `slip`=1 in this cycle.
  - `slip_count` += 1, saturating at 16'hFFFF.
  - Load `wait_cnt` with `SLIP_WAIT`, then go to WAIT.
- **WAIT:**
  - Each accepted block decrements `wait_cnt`; headers are ignored.
  - When `wait_cnt` reaches 0, go to TEST.
  - If `SLIP_WAIT`=0, SLIP goes directly to TEST.
- **Lock loss while locked:** occurs only via the `SH_INVALID_MAX` rule. Fewer invalid headers per window keep lock.
- **Forwarding:** when `m_axis_tready`=1, the output registers load:
  - `m_axis_tvalid <= s_axis_tvalid & block_lock`, using the registered lock value in that cycle, before any update.
  - `m_axis_ttype <= s_axis_ttype`, `m_axis_tdata <= s_axis_tdata`.
  - While `block_lock`=0, blocks are accepted and dropped.
- **Backpressure:** when `m_axis_tready`=0, all `m_axis_*` outputs hold. No block is accepted, so the FSM and counters freeze, except that a SLIP state still completes in one cycle.

## Timing
- **Reset values** (synchronous, `reset`=1 at a rising edge):
  - State = TEST; `sh_cnt` = `sh_invalid_cnt` = `wait_cnt` = 0.
  - `block_lock`=0, `slip`=0, `slip_count`=0, `m_axis_tvalid`=0.
  - `m_axis_ttype` and `m_axis_tdata` are 0.
- **Reset mid-operation:** reset takes priority over every transition, including SLIP. No `slip` pulse is issued in the reset cycle.
- **Datapath latency:** 1 cycle from an accepted input to `m_axis_tvalid`.
- **Lock timing:**
  - `block_lock` rises in the cycle after the acceptance of block number `SH_CNT_MAX` of a clean window.
  - `block_lock` falls in the cycle after the acceptance of the block that produces the `SH_INVALID_MAX`-th invalid header.
- **Slip timing:** `slip` asserts the cycle after the triggering block and lasts exactly 1 cycle. The earliest next TEST-counted block is `SLIP_WAIT` accepted blocks after the SLIP cycle.
- **Simultaneous events:** when invalid-limit and window-end are reached on the same block, the invalid-limit rule wins (lock lost, slip).
- **`s_axis_tready`:** has no dependency on the FSM state.

## Test plan
- **Acquisition:** after reset, 64 blocks with ttype=01 and `m_axis_tready`=1.
  - `block_lock`=1 the cycle after block 64.
  - The first forwarded block is block 65, with `m_axis_tvalid`=1 one cycle later.
- **Unlocked slip:** ttype=11 on the 3rd block after reset.
  - `slip`=1 for 1 cycle and `slip_count`=1.
  - The next 2 blocks are ignored, even if illegal.
  - Counting resumes, and lock follows 64 clean blocks.
- **Tolerance:** while locked, a 64-block window with 15 blocks of ttype=00.
  - `block_lock` stays 1 and no slip.
  - The next window is clean and lock holds.
- **Loss:** while locked, 16 invalid headers within one window.
  - `block_lock` falls the cycle after the 16th invalid header.
  - `slip` pulses the same cycle, `slip_count` increments, and output valid stops.
- **Backpressure:** hold `m_axis_tready`=0 for 10 cycles, starting mid-acquisition at `sh_cnt`=40.
  - Outputs hold and `sh_cnt` stays at 40.
  - After release, lock still requires exactly 24 further clean blocks.
- **Reset mid-WAIT:** assert `reset` for 1 cycle.
  - All outputs return to reset values.
  - No `slip` occurs, and acquisition restarts from `sh_cnt`=0.
